// File: rtl/hamming_pkg.sv
// hamming_pkg: shared types, widths and syndrome function for the Hamming receiver.
// Optional feature macro: HAMMING_SECDED_EN (adds overall parity bit p0, CW_W=8).
package hamming_pkg;
`ifdef HAMMING_SECDED_EN
  localparam int CW_W = 8;
`else
  localparam int CW_W = 7;
`endif
  // Data bit positions inside the codeword (bit i = Hamming position i+1)
  localparam int D1_POS = 2;
  localparam int D2_POS = 4;
  localparam int D3_POS = 5;
  localparam int D4_POS = 6;
  typedef enum logic [1:0] {IDLE, CAPTURE, DECODE, CORRECT} state_e;
  // Returns {s3,s2,s1}; a nonzero value is the 1-based position of a single flipped bit
  function automatic logic [2:0] syndrome_f(input logic [6:0] c);
    return {c[3] ^ c[4] ^ c[5] ^ c[6],
            c[1] ^ c[2] ^ c[5] ^ c[6],
            c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction
endpackage

// File: rtl/module_debounce.sv
// module_debounce: synchronizes an active-low button, debounces it and emits one press pulse.
// Ports: clk, rst_n (async active-low); btn_n_i raw active-low button;
//        press_o one-cycle pulse on each debounced 1->0 transition.
module module_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_d, btn_s, done;
  assign btn_s = sync_q[SYNC_STAGES-1];
  // The counter only runs while the synchronized input disagrees with the debounced level,
  // so any bounce back to the current level restarts the stability window.
  always_comb begin
    done    = (btn_s != level_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (btn_s == level_q || done) ? '0 : cnt_q + 1'b1;
    level_d = done ? btn_s : level_q;
    press_d = done & ~btn_s;
  end
  // Idle button level is high, so the chain and debounced level reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_n_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_o <= press_d;
    end
  end
endmodule

// File: rtl/module_hamming_rx.sv
// module_hamming_rx: samples a Hamming(7,4) codeword on a debounced press, corrects and holds data.
// Ports: clk, rst_n (async active-low); sw_code[CW_W] raw switches; btn_load_n raw load button;
//        data_out {d4,d3,d2,d1}; syndrome {s3,s2,s1}; err_single; err_double; valid (1-cycle pulse).
// Macro HAMMING_SECDED_EN enables the overall-parity bit and double-error detection.
module module_hamming_rx
  import hamming_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CW_W-1:0] sw_code,
  input  logic            btn_load_n,
  output logic [3:0]      data_out,
  output logic [2:0]      syndrome,
  output logic            err_single,
  output logic            err_double,
  output logic            valid
);
  state_e state_q;
  logic [CW_W-1:0] sw_sync_q [SYNC_STAGES];
  logic [CW_W-1:0] cw_q;
  logic [2:0] syn_q;
  logic op_q;
  logic press;
  logic [6:0] fix_d;
  logic [3:0] data_d;
  logic single_d, double_d;
  module_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_n_i(btn_load_n),
    .press_o(press)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= sw_code;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end
  always_comb begin
    fix_d = cw_q[6:0] ^ ((syn_q != 3'd0) ? (7'd1 << (syn_q - 3'd1)) : 7'd0);
`ifdef HAMMING_SECDED_EN
    // Odd overall parity means exactly one flipped bit (possibly p0 itself, then syn_q==0);
    // even parity with a nonzero syndrome means two flips, which cannot be corrected.
    double_d = (syn_q != 3'd0) && !op_q;
    single_d = op_q;
    data_d   = double_d ? data_out : {fix_d[D4_POS], fix_d[D3_POS], fix_d[D2_POS], fix_d[D1_POS]};
`else
    double_d = 1'b0;
    single_d = syn_q != 3'd0;
    data_d   = {fix_d[D4_POS], fix_d[D3_POS], fix_d[D2_POS], fix_d[D1_POS]};
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cw_q       <= '0;
      syn_q      <= '0;
      op_q       <= 1'b0;
      data_out   <= '0;
      syndrome   <= '0;
      err_single <= 1'b0;
      err_double <= 1'b0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press) begin
            cw_q    <= sw_sync_q[SYNC_STAGES-1];
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          syn_q   <= syndrome_f(cw_q[6:0]);
          op_q    <= ^cw_q;
          state_q <= DECODE;
        end
        DECODE: begin
          data_out   <= data_d;
          syndrome   <= syn_q;
          err_single <= single_d;
          err_double <= double_d;
          valid      <= 1'b1;
          state_q    <= CORRECT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_module_hamming_rx.sv
// tb_module_hamming_rx: table-driven scoreboard bench for module_hamming_rx (DEBOUNCE_CYCLES=8).
module tb_module_hamming_rx;
  import hamming_pkg::*;
  typedef struct {logic [3:0] d; logic [2:0] s; logic se; logic de;} exp_t;
  typedef struct {logic [6:0] cw; logic p0f; exp_t e;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_load_n = 1'b1;
  logic [CW_W-1:0] sw_code = '0;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic err_single, err_double, valid;
  exp_t sbq[$];
  exp_t me;
  vec_t vecs[$];
  int checks = 0, failures = 0, cyc = 0, vcnt = 0, vcyc = 0;
  // Press-to-valid from the cycle the button is driven low: 2 sync + 8 debounce + 3 FSM
  localparam int LAT = 13;
  module_hamming_rx #(.DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw_code(sw_code), .btn_load_n(btn_load_n),
    .data_out(data_out), .syndrome(syndrome), .err_single(err_single),
    .err_double(err_double), .valid(valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [CW_W-1:0] mkword(input logic [6:0] cw, input logic p0f);
`ifdef HAMMING_SECDED_EN
    return {(^cw) ^ p0f, cw};
`else
    return cw ^ 7'(p0f);
`endif
  endfunction
  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vcyc = cyc;
      if (sbq.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        me = sbq.pop_front();
        check("data_out", data_out, me.d);
        check("syndrome", syndrome, me.s);
        check("err_single", err_single, me.se);
        check("err_double", err_double, me.de);
      end
    end
  end
  task automatic load(input logic [6:0] cw, input logic p0f, input exp_t e, input string tag);
    int pc, v0;
    @(negedge clk);
    sw_code = mkword(cw, p0f);
    repeat (3) @(negedge clk);
    sbq.push_back(e);
    v0 = vcnt;
    btn_load_n = 1'b0;
    pc = cyc;
    repeat (12) @(negedge clk);
    sw_code = ~sw_code;
    repeat (4) @(negedge clk);
    btn_load_n = 1'b1;
    repeat (14) @(negedge clk);
    check({tag, "_pulses"}, vcnt - v0, 1);
    check({tag, "_latency"}, vcyc - pc, LAT);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_syn"}, syndrome, 0);
    check({tag, "_se"}, err_single, 0);
    check({tag, "_de"}, err_double, 0);
    check({tag, "_valid"}, valid, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int v0;
    vecs.push_back('{cw: 7'b0110011, p0f: 1'b0, e: '{d: 4'b0110, s: 3'd0, se: 1'b0, de: 1'b0}});
    for (int p = 1; p <= 7; p++)
      vecs.push_back('{cw: 7'b0110011 ^ (7'd1 << (p - 1)), p0f: 1'b0,
                       e: '{d: 4'b0110, s: 3'(p), se: 1'b1, de: 1'b0}});
    vecs.push_back('{cw: 7'b1010101, p0f: 1'b0, e: '{d: 4'b1011, s: 3'd0, se: 1'b0, de: 1'b0}});
    vecs.push_back('{cw: 7'b0000000, p0f: 1'b0, e: '{d: 4'b0000, s: 3'd0, se: 1'b0, de: 1'b0}});
    vecs.push_back('{cw: 7'b1111111, p0f: 1'b0, e: '{d: 4'b1111, s: 3'd0, se: 1'b0, de: 1'b0}});
    vecs.push_back('{cw: 7'b0010101, p0f: 1'b0, e: '{d: 4'b1011, s: 3'd7, se: 1'b1, de: 1'b0}});
    // Reset held while inputs toggle
    repeat (20) begin
      @(negedge clk);
      sw_code = CW_W'($urandom);
      btn_load_n = ~btn_load_n;
    end
    #1;
    check_zero("in_reset");
    check("in_reset_pulses", vcnt, 0);
    btn_load_n = 1'b1;
    sw_code = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_zero("after_reset");
    check("after_reset_pulses", vcnt, 0);
    foreach (vecs[i]) load(vecs[i].cw, vecs[i].p0f, vecs[i].e, $sformatf("vec%0d", i));
    // Bouncy press then long hold: exactly one decode
    v0 = vcnt;
    @(negedge clk);
    sw_code = mkword(7'b1010101, 1'b0);
    repeat (3) @(negedge clk);
    sbq.push_back('{d: 4'b1011, s: 3'd0, se: 1'b0, de: 1'b0});
    repeat (3) begin
      btn_load_n = 1'b0;
      repeat (3) @(negedge clk);
      btn_load_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    btn_load_n = 1'b0;
    repeat (50) @(negedge clk);
    btn_load_n = 1'b1;
    repeat (14) @(negedge clk);
    check("bounce_pulses", vcnt - v0, 1);
    // Reset asserted while the FSM sits in DECODE
    v0 = vcnt;
    sw_code = mkword(7'b1111111, 1'b0);
    repeat (3) @(negedge clk);
    btn_load_n = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    btn_load_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("abort_pulses", vcnt - v0, 0);
    load(7'b1111111, 1'b0, '{d: 4'b1111, s: 3'd0, se: 1'b0, de: 1'b0}, "after_abort");
`ifdef HAMMING_SECDED_EN
    load(7'b0110011, 1'b1, '{d: 4'b0110, s: 3'd0, se: 1'b1, de: 1'b0}, "p0_err");
    load(7'b1010101, 1'b0, '{d: 4'b1011, s: 3'd0, se: 1'b0, de: 1'b0}, "pre_double");
    load(7'b0110011 ^ 7'b0100100, 1'b0, '{d: 4'b1011, s: 3'd5, se: 1'b0, de: 1'b1}, "double");
`endif
    check("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
